regfile_mp: RTL and testbench

//  Parametrised multi-port general-purpose register file for the next core generation.

---
 rtl/regfile_mp_if.sv | 32 +++
 rtl/regfile_mp.sv | 104 ++++++++++
 tb/tb_regfile_mp.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Register-file bus: write ports, read ports, scoreboard pend side and ready.
// The master modport is the issue/writeback side; the slave modport is the register file.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                     wen0_i;
    logic [ADDR_W-1:0]        waddr0_i;
    logic [DATA_W-1:0]        wdata0_i;
    logic                     wen1_i;
    logic [ADDR_W-1:0]        waddr1_i;
    logic [DATA_W-1:0]        wdata1_i;
    logic [NUM_RD*ADDR_W-1:0] raddr_i;
    logic [NUM_RD*DATA_W-1:0] rdata_o;
    logic [NUM_RD-1:0]        pend_o;
    logic                     pend_set_i;
    logic [ADDR_W-1:0]        pend_addr_i;
    logic                     ready_o;

    modport master (
        output wen0_i, waddr0_i, wdata0_i, wen1_i, waddr1_i, wdata1_i,
        output raddr_i, pend_set_i, pend_addr_i,
        input  rdata_o, pend_o, ready_o
    );

    modport slave (
        input  wen0_i, waddr0_i, wdata0_i, wen1_i, waddr1_i, wdata1_i,
        input  raddr_i, pend_set_i, pend_addr_i,
        output rdata_o, pend_o, ready_o
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: two bypassed write ports, hardwired-zero reg 0,
// sequential clear sweep after reset and a per-register pending-write scoreboard.
module regfile_mp #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_RD     = 2,
    parameter int CLR_ON_RST = 1
) (
    input logic         clk_i,
    input logic         rst_i,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] ST_INIT  = (CLR_ON_RST != 0) ? ST_CLEAR : ST_RUN;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic run, we0, we1, set_act;

    always_comb begin
        run     = !rst_i && (state_q == ST_RUN);
        we0     = run && bus.wen0_i && (bus.waddr0_i != '0);
        we1     = run && bus.wen1_i && (bus.waddr1_i != '0);
        set_act = run && bus.pend_set_i && (bus.pend_addr_i != '0);
    end

    // The counter wraps to 0 after writing DEPTH-1; that wrapped value is the
    // one idle cycle spent in CLEAR before handing over to RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        mem_d   = mem_q;
        if (!rst_i && state_q == ST_CLEAR) begin
            if (cnt_q == '0) begin
                state_d = ST_RUN;
            end else begin
                mem_d[cnt_q] = '0;
                cnt_d        = cnt_q + 1'b1;
            end
        end
        if (we0) begin
            mem_d[bus.waddr0_i]  = bus.wdata0_i;
            pend_d[bus.waddr0_i] = 1'b0;
        end
        if (we1) begin
            mem_d[bus.waddr1_i]  = bus.wdata1_i;
            pend_d[bus.waddr1_i] = 1'b0;
        end
        if (set_act) begin
            pend_d[bus.pend_addr_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            cnt_q[0] <= 1'b1;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
        mem_q <= mem_d;
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              pd;
        bus.rdata_o = '0;
        bus.pend_o  = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            ra = bus.raddr_i[k*ADDR_W +: ADDR_W];
            rd = '0;
            pd = 1'b0;
            if (run && ra != '0) begin
                if (we1 && bus.waddr1_i == ra)      rd = bus.wdata1_i;
                else if (we0 && bus.waddr0_i == ra) rd = bus.wdata0_i;
                else                                rd = mem_q[ra];
                pd = pend_q[ra]
                     && !(we1 && bus.waddr1_i == ra)
                     && !(we0 && bus.waddr0_i == ra)
                     && !(set_act && bus.pend_addr_i == ra);
            end
            bus.rdata_o[k*DATA_W +: DATA_W] = rd;
            bus.pend_o[k]                   = pd;
        end
    end

    always_comb begin
        bus.ready_o = rst_i ? (CLR_ON_RST == 0) : (state_q == ST_RUN);
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp against an array/queue-level reference model,
// plus directed checks of sweep timing, bypass, write priority, reg 0 and scoreboard.
module tb_regfile_mp;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CLR_ON_RST(1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] m_mem [DEPTH];
    bit   [DEPTH-1:0] m_pend;
    int   m_since;   // non-reset edges since the last reset edge

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !rst && (m_since >= DEPTH);
    endfunction

    function automatic logic [DW-1:0] m_rdata(input logic [AW-1:0] ra);
        if (!m_ready() || ra == 0)                return '0;
        if (bus.wen1_i && bus.waddr1_i == ra)     return bus.wdata1_i;
        if (bus.wen0_i && bus.waddr0_i == ra)     return bus.wdata0_i;
        return m_mem[ra];
    endfunction

    function automatic logic m_pend_out(input logic [AW-1:0] ra);
        if (!m_ready() || ra == 0)                return 1'b0;
        if (bus.wen1_i && bus.waddr1_i == ra)     return 1'b0;
        if (bus.wen0_i && bus.waddr0_i == ra)     return 1'b0;
        if (bus.pend_set_i && bus.pend_addr_i == ra) return 1'b0;
        return m_pend[ra];
    endfunction

    task automatic idle();
        bus.wen0_i = 0; bus.waddr0_i = '0; bus.wdata0_i = '0;
        bus.wen1_i = 0; bus.waddr1_i = '0; bus.wdata1_i = '0;
        bus.raddr_i = '0; bus.pend_set_i = 0; bus.pend_addr_i = '0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    task automatic drive_random();
        bus.wen0_i = 1'($urandom_range(0, 1)); bus.waddr0_i = rand_addr(); bus.wdata0_i = $urandom;
        bus.wen1_i = 1'($urandom_range(0, 1)); bus.waddr1_i = rand_addr(); bus.wdata1_i = $urandom;
        for (int k = 0; k < NR; k++) bus.raddr_i[k*AW +: AW] = rand_addr();
        bus.pend_set_i = 1'($urandom_range(0, 1)); bus.pend_addr_i = rand_addr();
    endtask

    // Settle, then compare all outputs against the model for the current inputs.
    task automatic settle_check();
        logic [AW-1:0] ra;
        #2;
        check("ready", {63'd0, bus.ready_o}, {63'd0, m_ready()});
        for (int k = 0; k < NR; k++) begin
            ra = bus.raddr_i[k*AW +: AW];
            check($sformatf("rdata%0d", k), {32'd0, bus.rdata_o[k*DW +: DW]}, {32'd0, m_rdata(ra)});
            check($sformatf("pend%0d", k), {63'd0, bus.pend_o[k]}, {63'd0, m_pend_out(ra)});
        end
    endtask

    task automatic tick();
        bit rdy;
        rdy = m_ready();
        @(posedge clk);
        if (rst) begin
            m_since = 0;
            m_pend  = '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else begin
            if (m_since < 100000) m_since++;
            if (rdy) begin
                if (bus.wen0_i && bus.waddr0_i != 0) begin
                    m_mem[bus.waddr0_i] = bus.wdata0_i; m_pend[bus.waddr0_i] = 1'b0;
                end
                if (bus.wen1_i && bus.waddr1_i != 0) begin
                    m_mem[bus.waddr1_i] = bus.wdata1_i; m_pend[bus.waddr1_i] = 1'b0;
                end
                if (bus.pend_set_i && bus.pend_addr_i != 0) m_pend[bus.pend_addr_i] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic step();
        settle_check();
        tick();
    endtask

    // One reset cycle, one edge, then count the cycles ready stays low.
    task automatic sweep_and_count(input string tag);
        int lows;
        rst = 1; drive_random(); step();
        rst = 0; drive_random(); step();
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            drive_random();
            settle_check();
            if (bus.ready_o === 1'b1) break;
            lows++;
            tick();
        end
        check(tag, 64'(lows), 64'(DEPTH - 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        m_since = 0;
        m_pend  = '0;
        idle();
        rst = 1;
        #1;

        sweep_and_count("sweep_len");

        // Reset when the sweep has advanced to count 10: restart from 1.
        rst = 1; idle(); step();
        rst = 0;
        for (int i = 0; i < 9; i++) begin drive_random(); step(); end
        sweep_and_count("sweep_restart_len");

        // Bypass on port 0, then stored value.
        idle(); bus.wen0_i = 1; bus.waddr0_i = 5; bus.wdata0_i = 32'hA5A5_A5A5;
        bus.raddr_i[0 +: AW] = 5;
        settle_check(); check("byp0", {32'd0, bus.rdata_o[0 +: DW]}, 64'hA5A5_A5A5); tick();
        idle(); bus.raddr_i[0 +: AW] = 5;
        settle_check(); check("stored0", {32'd0, bus.rdata_o[0 +: DW]}, 64'hA5A5_A5A5); tick();

        // Both write ports to reg 7: port 1 wins.
        idle(); bus.wen0_i = 1; bus.waddr0_i = 7; bus.wdata0_i = 32'h11;
        bus.wen1_i = 1; bus.waddr1_i = 7; bus.wdata1_i = 32'h22;
        bus.raddr_i[AW +: AW] = 7;
        settle_check(); check("prio_byp", {32'd0, bus.rdata_o[DW +: DW]}, 64'h22); tick();
        idle(); bus.raddr_i[AW +: AW] = 7;
        settle_check(); check("prio_stored", {32'd0, bus.rdata_o[DW +: DW]}, 64'h22); tick();

        // Register 0 stays zero and never becomes pending.
        idle(); bus.wen0_i = 1; bus.wdata0_i = '1; bus.wen1_i = 1; bus.wdata1_i = '1;
        bus.pend_set_i = 1;
        settle_check(); check("zero_byp", {32'd0, bus.rdata_o[0 +: DW]}, 64'h0); tick();
        idle();
        settle_check();
        check("zero_rd", {32'd0, bus.rdata_o[0 +: DW]}, 64'h0);
        check("zero_pend", {62'd0, bus.pend_o}, 64'h0);
        tick();

        // Scoreboard sequence on reg 3.
        idle(); bus.pend_set_i = 1; bus.pend_addr_i = 3; step();
        idle(); bus.raddr_i[0 +: AW] = 3;
        settle_check(); check("pend_set", {63'd0, bus.pend_o[0]}, 64'h1); tick();
        idle(); bus.raddr_i[0 +: AW] = 3; bus.wen1_i = 1; bus.waddr1_i = 3; bus.wdata1_i = 32'h33;
        settle_check(); check("pend_wr_mask", {63'd0, bus.pend_o[0]}, 64'h0); tick();
        idle(); bus.raddr_i[0 +: AW] = 3;
        settle_check(); check("pend_cleared", {63'd0, bus.pend_o[0]}, 64'h0); tick();
        idle(); bus.pend_set_i = 1; bus.pend_addr_i = 3; bus.wen0_i = 1; bus.waddr0_i = 3;
        bus.raddr_i[0 +: AW] = 3;
        settle_check(); check("pend_set_mask", {63'd0, bus.pend_o[0]}, 64'h0); tick();
        idle(); bus.raddr_i[0 +: AW] = 3;
        settle_check(); check("pend_set_wins", {63'd0, bus.pend_o[0]}, 64'h1); tick();

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            drive_random();
            step();
        end

        rst = 0; idle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
